log_ram_ctrl: RTL and testbench

Sequencer for the capture RAM. It arms on a rising edge of the micro's run request and clears the write pointer. It then writes one datapath sample per valid strobe until the RAM is full, and freezes there. In IDLE/FULL the micro may read the RAM back through the same address port. The block generates all RAM address/enable controls; the data bus is wired RAM-to-datapath/micro outside this block.

---
 rtl/log_ram_ctrl_if.sv | 29 ++
 rtl/log_ram_ctrl.sv | 108 ++++++++++
 tb/tb_log_ram_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/log_ram_ctrl_if.sv
// Capture RAM sequencer bus: micro/datapath requests in, RAM controls and status out.
interface log_ram_ctrl_if #(
  parameter int NB_ADDR = 3
);
  logic               i_log_run;
  logic               i_sample_valid;
  logic               i_rd_req;
  logic [NB_ADDR-1:0] i_rd_addr;
  logic               o_ram_we;
  logic               o_ram_re;
  logic [NB_ADDR-1:0] o_ram_addr;
  logic               o_rd_valid;
  logic               o_rd_err;
  logic               o_full_mem;
  logic               o_busy;
  logic [NB_ADDR:0]   o_count;

  modport master (
    output i_log_run, i_sample_valid, i_rd_req, i_rd_addr,
    input  o_ram_we, o_ram_re, o_ram_addr, o_rd_valid, o_rd_err,
           o_full_mem, o_busy, o_count
  );

  modport slave (
    input  i_log_run, i_sample_valid, i_rd_req, i_rd_addr,
    output o_ram_we, o_ram_re, o_ram_addr, o_rd_valid, o_rd_err,
           o_full_mem, o_busy, o_count
  );
endinterface

// File: rtl/log_ram_ctrl.sv
// Capture RAM sequencer: arms on a run rising edge, clears the write pointer,
// writes one sample per strobe until the RAM is full, and serves micro reads
// while idle or full.
module log_ram_ctrl #(
  parameter int NB_ADDR = 3
) (
  input  logic         clock,
  input  logic         i_reset,
  log_ram_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOG   = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  logic [1:0]         state;
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR:0]   cnt;
  logic               full;
  logic               rd_valid;
  logic               rd_err;
  logic               run_d;

  logic start;
  logic wr_en;
  logic rd_ok;
  logic rd_rej;

  // Request decode: start edge, write strobe, read accept/reject.
  always_comb begin
    start  = bus.i_log_run & ~run_d;
    wr_en  = (state == ST_LOG) & bus.i_sample_valid;
    rd_ok  = ((state == ST_IDLE) | (state == ST_FULL)) & bus.i_rd_req & ~start;
    rd_rej = bus.i_rd_req & ~rd_ok;
  end

  // RAM controls: read address only while a read is accepted, else write pointer.
  always_comb begin
    bus.o_ram_we   = wr_en;
    bus.o_ram_re   = rd_ok;
    bus.o_ram_addr = rd_ok ? bus.i_rd_addr : wr_ptr;
    bus.o_busy     = (state == ST_CLEAR) | (state == ST_LOG);
    bus.o_full_mem = full;
    bus.o_count    = cnt;
    bus.o_rd_valid = rd_valid;
    bus.o_rd_err   = rd_err;
  end

  // Run edge history; reset high so a level already asserted is not a start.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) run_d <= 1'b1;
    else          run_d <= bus.i_log_run;
  end

  // Read response pulses, one cycle after the request.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_rej;
    end
  end

  // Capture sequencer: state, write pointer, word count and full flag.
  // In LOG a restart still commits the coincident sample; restart wins over
  // reaching the last address, since CLEAR resets the full flag anyway.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          wr_ptr <= '0;
          cnt    <= '0;
          full   <= 1'b0;
          state  <= ST_LOG;
        end
        ST_LOG: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + NB_ADDR'(1);
            cnt    <= cnt + (NB_ADDR+1)'(1);
          end
          if (start) begin
            state <= ST_CLEAR;
          end else if (wr_en && (wr_ptr == LAST_ADDR)) begin
            state <= ST_FULL;
            full  <= 1'b1;
          end
        end
        default: begin
          if (start) state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_log_ram_ctrl.sv
// Bench for log_ram_ctrl: directed stimulus pushes expected RAM/read events
// (cycle index + address) into per-kind queues; a negedge monitor pops and
// compares whenever the DUT shows a write, read, read-valid or read-error.
module tb_log_ram_ctrl;

  localparam int NB_ADDR = 3;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  logic clock = 1'b0;
  logic i_reset;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // 0: write, 1: read, 2: read valid, 3: read error
  ev_t q[4][$];

  log_ram_ctrl_if #(.NB_ADDR(NB_ADDR)) bus ();

  log_ram_ctrl #(.NB_ADDR(NB_ADDR)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expect an event of kind k at the negedge 'off' cycles ahead (-1 addr = don't care).
  task automatic expect_ev(input int k, input int off, input int a);
    ev_t e;
    e.cyc  = cyc + off;
    e.addr = a;
    q[k].push_back(e);
  endtask

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic stat(input string nm, input int b, input int c, input int f);
    cmp({nm, "_busy"},  int'(bus.o_busy), b);
    cmp({nm, "_count"}, int'(bus.o_count), c);
    cmp({nm, "_full"},  int'(bus.o_full_mem), f);
  endtask

  function automatic string kname(input int k);
    case (k)
      0: return "write";
      1: return "read";
      2: return "rd_valid";
      default: return "rd_err";
    endcase
  endfunction

  task automatic chk(input int k, input bit fired, input int a);
    ev_t e;
    while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
      e = q[k].pop_front();
      checks++;
      errors++;
      $display("FAIL %s_missing actual=none required=cycle %0d addr %0d", kname(k), e.cyc, e.addr);
    end
    if (fired) begin
      checks++;
      if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
        errors++;
        $display("FAIL %s_unexpected actual=cycle %0d addr %0d required=no event", kname(k), cyc, a);
      end else begin
        e = q[k].pop_front();
        if (e.addr >= 0 && e.addr != a) begin
          errors++;
          $display("FAIL %s_addr actual=%0d required=%0d (cycle %0d)", kname(k), a, e.addr, cyc);
        end
      end
    end
  endtask

  // Monitor: one sample per cycle, away from the active edge.
  always @(negedge clock) begin
    cyc++;
    chk(0, bus.o_ram_we,   int'(bus.o_ram_addr));
    chk(1, bus.o_ram_re,   int'(bus.o_ram_addr));
    chk(2, bus.o_rd_valid, -1);
    chk(3, bus.o_rd_err,   -1);
    if (bus.o_ram_we && bus.o_ram_re) begin
      checks++;
      errors++;
      $display("FAIL we_re_exclusive actual=both required=one (cycle %0d)", cyc);
    end
  end

  initial begin
    bus.i_log_run      = 1'b1;
    bus.i_sample_valid = 1'b0;
    bus.i_rd_req       = 1'b0;
    bus.i_rd_addr      = '0;
    i_reset            = 1'b1;
    #1 i_reset = 1'b0;

    // Reset with run held high; release and hold: no start.
    repeat (2) @(posedge clock);
    #1;
    stat("reset", 0, 0, 0);
    cmp("reset_rd_valid", int'(bus.o_rd_valid), 0);
    cmp("reset_rd_err",   int'(bus.o_rd_err), 0);
    cmp("reset_addr",     int'(bus.o_ram_addr), 0);
    i_reset = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      stat("run_level", 0, 0, 0);
    end

    // Rising edge, continuous strobes: one CLEAR cycle then addresses 0..7.
    bus.i_log_run = 1'b0;
    tick();
    bus.i_log_run      = 1'b1;
    bus.i_sample_valid = 1'b1;
    tick();
    stat("clear", 1, 0, 0);
    tick();
    for (int unsigned i = 0; i < 8; i++) begin
      cmp("log_full_before", int'(bus.o_full_mem), 0);
      expect_ev(0, 1, int'(i));
      tick();
    end
    stat("full", 0, 8, 1);
    cmp("full_idle_addr", int'(bus.o_ram_addr), 0);
    repeat (3) tick();
    bus.i_sample_valid = 1'b0;

    // Back-to-back reads in FULL.
    bus.i_rd_req = 1'b1;
    for (int unsigned a = 2; a <= 4; a++) begin
      bus.i_rd_addr = NB_ADDR'(a);
      expect_ev(1, 1, int'(a));
      expect_ev(2, 2, -1);
      tick();
    end
    bus.i_rd_req = 1'b0;
    repeat (2) tick();
    stat("full_hold", 0, 8, 1);

    // Read coincident with a start is rejected; capture restarts.
    bus.i_log_run = 1'b0;
    tick();
    bus.i_log_run = 1'b1;
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = 3'd5;
    expect_ev(3, 2, -1);
    tick();
    bus.i_rd_req = 1'b0;
    stat("restart_clear", 1, 8, 1);
    tick();
    stat("restart_log", 1, 0, 0);

    // Sparse strobes (every 3rd cycle); a read attempt mid-capture is rejected.
    for (int unsigned i = 0; i < 8; i++) begin
      bus.i_sample_valid = 1'b1;
      expect_ev(0, 1, int'(i));
      tick();
      bus.i_sample_valid = 1'b0;
      if (i == 3) begin
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 3'd1;
        expect_ev(3, 2, -1);
      end
      #1;
      cmp("sparse_idle_addr", int'(bus.o_ram_addr), int'((i + 1) % 8));
      tick();
      bus.i_rd_req = 1'b0;
      if (i == 6) stat("sparse_pre_full", 1, 7, 0);
      tick();
    end
    stat("sparse_full", 0, 8, 1);

    // Restart after 4 writes; coincident sample still written.
    bus.i_log_run = 1'b0;
    tick();
    bus.i_log_run = 1'b1;
    tick();
    bus.i_log_run      = 1'b0;
    bus.i_sample_valid = 1'b1;
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      expect_ev(0, 1, int'(i));
      tick();
    end
    bus.i_log_run = 1'b1;
    expect_ev(0, 1, 4);
    tick();
    stat("restart2_clear", 1, 5, 0);
    tick();
    stat("restart2_log", 1, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      expect_ev(0, 1, int'(i));
      tick();
    end

    // Asynchronous reset mid-capture.
    bus.i_sample_valid = 1'b0;
    i_reset = 1'b0;
    #1;
    stat("async_reset", 0, 0, 0);
    #2 i_reset = 1'b1;
    repeat (3) tick();
    stat("post_reset", 0, 0, 0);
    cmp("post_reset_addr", int'(bus.o_ram_addr), 0);

    repeat (2) tick();
    for (int k = 0; k < 4; k++) cmp({kname(k), "_queue_left"}, q[k].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
